// File: rtl/isa_pkg.sv
// Shared ISA constants, PC-select encodings and fetch FSM states.
// Exports: LDM_OP, NOP_WORD, vector addresses, PC_SEL_*, fetch_state_e, is_ldm().
package isa_pkg;

   localparam logic [4:0]  LDM_OP         = 5'b10010;
   localparam logic [15:0] NOP_WORD       = 16'h0000;
   localparam logic [31:0] RESET_VEC_ADDR = 32'd0;
   localparam logic [31:0] INT_VEC_ADDR   = 32'd2;

   localparam logic [1:0] PC_SEL_SEQ = 2'b00;
   localparam logic [1:0] PC_SEL_JMP = 2'b01;
   localparam logic [1:0] PC_SEL_MEM = 2'b10;

   typedef enum logic [2:0] {
      BOOT_HI,
      BOOT_LO,
      RUN,
      INT_HI,
      INT_LO
   } fetch_state_e;

   function automatic logic is_ldm(input logic [15:0] word);
      return word[15:11] == LDM_OP;
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with half-word vector load, full target load and increment.
// Ports: clk, rst, i_ld_hi/i_ld_lo (vector halves), i_ld_full (redirect),
//        i_inc (sequential), i_half, i_target, o_pc, o_pc_inc (pc + 1).
module pc_reg
   import isa_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_ld_hi,
   input  logic            i_ld_lo,
   input  logic            i_ld_full,
   input  logic            i_inc,
   input  logic [15:0]     i_half,
   input  logic [PC_W-1:0] i_target,
   output logic [PC_W-1:0] o_pc,
   output logic [PC_W-1:0] o_pc_inc
);

   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_inc;

   // Wraps modulo 2^PC_W naturally.
   assign w_pc_inc = r_pc + PC_W'(1);
   assign o_pc     = r_pc;
   assign o_pc_inc = w_pc_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= '0;
      end else if (i_ld_full) begin
         r_pc <= i_target;
      end else if (i_ld_hi) begin
         r_pc[PC_W-1:PC_W-16] <= i_half;
      end else if (i_ld_lo) begin
         r_pc[15:0] <= i_half;
      end else if (i_inc) begin
         r_pc <= w_pc_inc;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch FSM, redirect/stall/interrupt priority and IF/ID register.
// Ports: clk, rst, imem_addr/imem_data, pc_sel, pc_jmp, mem_pc,
//        fetch_pc_enable, load_use, freeze, int_req -> instruction, ldm_value,
//        interrupt, pc_next_saved, valid.
module fetch_stage
   import isa_pkg::*;
#(
   parameter int width = 16,
   parameter int PC_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [width-1:0] imem_data,
   input  logic [1:0]       pc_sel,
   input  logic [PC_W-1:0]  pc_jmp,
   input  logic [PC_W-1:0]  mem_pc,
   input  logic             fetch_pc_enable,
   input  logic             load_use,
   input  logic             freeze,
   input  logic             int_req,
   output logic [width-1:0] instruction,
   output logic             ldm_value,
   output logic             interrupt,
   output logic [PC_W-1:0]  pc_next_saved,
   output logic             valid
);

   fetch_state_e r_state;
   fetch_state_e w_next;

   logic            r_ldm_pending;
   logic            r_int_latched;

   logic            w_stall;
   logic            w_redirect;
   logic            w_take_int;
   logic            w_seq;
   logic            w_ld_hi;
   logic            w_ld_lo;
   logic [PC_W-1:0] w_target;
   logic [PC_W-1:0] w_pc;
   logic [PC_W-1:0] w_pc_inc;

   assign w_stall = load_use | freeze | ~fetch_pc_enable;

   pc_reg #(
      .PC_W(PC_W)
   ) u_pc_reg (
      .clk      (clk),
      .rst      (rst),
      .i_ld_hi  (w_ld_hi),
      .i_ld_lo  (w_ld_lo),
      .i_ld_full(w_redirect),
      .i_inc    (w_seq),
      .i_half   (imem_data[15:0]),
      .i_target (w_target),
      .o_pc     (w_pc),
      .o_pc_inc (w_pc_inc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= BOOT_HI;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      imem_addr  = w_pc;
      w_ld_hi    = 1'b0;
      w_ld_lo    = 1'b0;
      w_redirect = 1'b0;
      w_take_int = 1'b0;
      w_seq      = 1'b0;
      w_target   = pc_jmp;
      unique case (r_state)
         BOOT_HI: begin
            imem_addr = RESET_VEC_ADDR;
            w_ld_hi   = 1'b1;
            w_next    = BOOT_LO;
         end
         BOOT_LO: begin
            imem_addr = RESET_VEC_ADDR + 32'd1;
            w_ld_lo   = 1'b1;
            w_next    = RUN;
         end
         RUN: begin
            if (pc_sel == PC_SEL_JMP || pc_sel == PC_SEL_MEM) begin
               w_redirect = 1'b1;
               if (pc_sel == PC_SEL_MEM) w_target = mem_pc;
            end else if (!w_stall) begin
               // Never split an LDM from its immediate word.
               if (r_int_latched && !r_ldm_pending) begin
                  w_take_int = 1'b1;
                  w_next     = INT_HI;
               end else begin
                  w_seq = 1'b1;
               end
            end
         end
         INT_HI: begin
            imem_addr = INT_VEC_ADDR;
            w_ld_hi   = 1'b1;
            w_next    = INT_LO;
         end
         INT_LO: begin
            imem_addr = INT_VEC_ADDR + 32'd1;
            w_ld_lo   = 1'b1;
            w_next    = RUN;
         end
         default: begin
            w_next = BOOT_HI;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_int_latched <= 1'b0;
         r_ldm_pending <= 1'b0;
      end else begin
         r_int_latched <= w_take_int ? 1'b0 : (r_int_latched | int_req);
         if (w_redirect) begin
            r_ldm_pending <= 1'b0;
         end else if (w_seq) begin
            // The immediate itself never re-arms, whatever its bits.
            r_ldm_pending <= r_ldm_pending ? 1'b0 : is_ldm(imem_data[15:0]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instruction   <= NOP_WORD;
         ldm_value     <= 1'b0;
         interrupt     <= 1'b0;
         pc_next_saved <= '0;
         valid         <= 1'b0;
      end else begin
         interrupt <= 1'b0;
         if (w_seq) begin
            instruction   <= imem_data;
            valid         <= 1'b1;
            ldm_value     <= r_ldm_pending;
            pc_next_saved <= w_pc_inc;
         end else if (w_take_int) begin
            instruction   <= NOP_WORD;
            valid         <= 1'b0;
            ldm_value     <= 1'b0;
            interrupt     <= 1'b1;
            pc_next_saved <= w_pc;
         end else if (w_redirect || r_state != RUN) begin
            instruction <= NOP_WORD;
            valid       <= 1'b0;
            ldm_value   <= 1'b0;
         end
      end
   end

endmodule
